ir_nec_slicer: RTL and testbench
================================

IR_NEC_SLICER -- requirements
Module: ir_nec_slicer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 2500, clk cycles per sample tick (50 MHz -> 50 us tick).
REQ-002 SHALL provide parameter NBITS, default 32, data bits per frame.
REQ-003 SHALL provide parameter TO_TICKS, default 220, level-duration timeout in ticks.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ir_in  input  1  raw IR receiver output, asynchronous; idle high, mark = low.
REQ-007 SHALL have port bit_out  output  1  decoded data bit; feeds the downstream shift register serial input.
REQ-008 SHALL have port bit_strobe  output  1  one-clk pulse; bit_out valid in this cycle; drives the downstream shift clock.
REQ-009 SHALL have port frame_en  output  1  high while a frame is being received; drives the downstream enable.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse, valid frame with NBITS bits completed.
REQ-011 SHALL have port repeat_pulse  output  1  one-clk pulse, valid NEC repeat code received.
REQ-012 SHALL have port err  output  1  one-clk pulse, protocol violation detected.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL synchronise ir_in via two flip-flops; edge detection uses the synchronised value and its one-cycle delay.
REQ-015 SHALL generate a one-clk tick every TICK_DIV clk cycles from a free-running prescaler.
REQ-016 SHALL keep an 8-bit width counter: cleared on every synchronised edge, +1 per tick, saturating at 255.
REQ-017 SHALL classify each level on the edge that ends it, using the width counter value before clearing; bounds inclusive.
REQ-018 Windows (ticks): leader mark 160..200; leader space 80..100; repeat space 36..54; bit/stop mark 7..16; space-0 7..16; space-1 26..42.
REQ-019 SHALL implement states IDLE, LMARK, LSPACE, DMARK, DSPACE, TRAIL, RTRAIL, HOLD.
REQ-020 IDLE: falling edge -> LMARK.
REQ-021 LMARK: rising edge with leader-mark width -> LSPACE; otherwise -> HOLD with err.
REQ-022 LSPACE: falling edge with leader-space width -> DMARK, frame_en set, bit counter cleared; repeat-space width -> RTRAIL; otherwise -> HOLD with err.
REQ-023 DMARK: rising edge with mark width -> DSPACE; otherwise -> HOLD with err.
REQ-024 DSPACE: falling edge with space-0 or space-1 width -> bit_strobe with bit_out 0/1, bit counter +1; next state TRAIL when counter reaches NBITS, else DMARK; any other width -> HOLD with err.
REQ-025 TRAIL: rising edge with mark width -> frame_done, IDLE; otherwise -> HOLD with err.
REQ-026 RTRAIL: rising edge with mark width -> repeat_pulse, IDLE; otherwise -> HOLD with err.
REQ-027 In any state except IDLE and HOLD, width counter reaching TO_TICKS SHALL raise err and enter HOLD.
REQ-028 HOLD: remain until synchronised line high for TO_TICKS ticks, then IDLE; no err repeats while in HOLD.
REQ-029 bit_strobe, frame_done, repeat_pulse and err SHALL be registered, asserted exactly 3 clk cycles after the causing ir_in edge.
REQ-030 bit_out SHALL hold its value until the next bit_strobe.
REQ-031 frame_en SHALL stay high through the frame_done or err cycle and go low the cycle after; it is never high in IDLE or HOLD.
REQ-032 At most one of frame_done, repeat_pulse, err SHALL be high in any cycle.
REQ-033 Bit counter SHALL be 6 bits wide; NBITS is at most 63.

Reset
REQ-034 With reset low at a clk edge: state IDLE; prescaler, width counter, bit counter cleared; synchroniser flops set to 1; all outputs 0.
REQ-035 Reset low mid-frame SHALL abort without err or frame_done; after release, the first falling edge starts a new leader.

Verification
REQ-036 Frame 0x00FF_A25D, NEC timing (9 ms / 4.5 ms / 562 us / 562 or 1687 us) -> 32 bit_strobe pulses, bits MSB-first 0000_0000_1111_1111_1010_0010_0101_1101, then one frame_done; err never high.
REQ-037 Leader then repeat space 2.25 ms, 562 us mark -> one repeat_pulse; no bit_strobe, frame_en stays 0.
REQ-038 Leader mark 5 ms -> err 3 clk after rising edge; state HOLD; frame_en 0; IDLE after 11 ms idle-high.
REQ-039 Line held low 12 ms after bit 10 -> err when width counter reaches 220; exactly 10 bit_strobes seen; no frame_done.
REQ-040 Reset pulsed low during bit 20 -> all outputs 0 next cycle, no err; following full frame decodes correctly.
REQ-041 Space of 1.1 ms (22 ticks, between windows) -> err; frame_en falls the following cycle.

Source files
------------

// File: rtl/ir_nec_slicer.sv
// NEC IR pulse-distance slicer: turns raw receiver levels into a serial bit stream
// (bit_out/bit_strobe) plus frame, repeat and error strobes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   ir_in        raw IR receiver output (asynchronous, idle high, mark low)
//   bit_out      decoded data bit, held until the next bit_strobe
//   bit_strobe   one-clk pulse, bit_out valid
//   frame_en     high while a data frame is being received
//   frame_done   one-clk pulse, NBITS-bit frame completed
//   repeat_pulse one-clk pulse, NEC repeat code received
//   err          one-clk pulse, protocol violation or timeout
//   busy         high whenever the decoder is not idle
module ir_nec_slicer #(
    parameter int TICK_DIV = 2500,
    parameter int NBITS    = 32,
    parameter int TO_TICKS = 220
) (
    input  logic clk,
    input  logic reset,
    input  logic ir_in,
    output logic bit_out,
    output logic bit_strobe,
    output logic frame_en,
    output logic frame_done,
    output logic repeat_pulse,
    output logic err,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE, LMARK, LSPACE, DMARK, DSPACE, TRAIL, RTRAIL, HOLD
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [5:0] NB = 6'(NBITS);

    state_t state, state_d;

    logic          s1, s2, s3;
    logic [PW-1:0] pre;
    logic          tick;
    logic [7:0]    width;
    logic [5:0]    bit_cnt, bit_cnt_d;
    logic          edge_any, rise, fall, tmo;
    logic          bit_d, strobe_d, done_d, rep_d, err_d, fen_d;
    logic          fail;

    function automatic logic in_win(input logic [7:0] w, input int lo, input int hi);
        return (int'(w) >= lo) && (int'(w) <= hi);
    endfunction

    // s2 is the synchronised line, s3 its one-cycle delay
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= ir_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_any = s2 ^ s3;
    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;

    assign tick = (pre == PMAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Duration of the current level in ticks; classification reads the
    // value still held in the edge cycle, before it is cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            width <= '0;
        end else if (edge_any) begin
            width <= '0;
        end else if (tick && width != 8'hFF) begin
            width <= width + 8'd1;
        end
    end

    assign tmo = (int'(width) >= TO_TICKS);

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        bit_d     = bit_out;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        rep_d     = 1'b0;
        fail      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) state_d = LMARK;
            end
            LMARK: begin
                if (rise) begin
                    if (in_win(width, 160, 200)) state_d = LSPACE;
                    else fail = 1'b1;
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            LSPACE: begin
                if (fall) begin
                    if (in_win(width, 80, 100)) begin
                        state_d   = DMARK;
                        bit_cnt_d = '0;
                    end else if (in_win(width, 36, 54)) begin
                        state_d = RTRAIL;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            DMARK: begin
                if (rise) begin
                    if (in_win(width, 7, 16)) state_d = DSPACE;
                    else fail = 1'b1;
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            DSPACE: begin
                if (fall) begin
                    if (in_win(width, 7, 16) || in_win(width, 26, 42)) begin
                        bit_d     = in_win(width, 26, 42);
                        strobe_d  = 1'b1;
                        bit_cnt_d = bit_cnt + 6'd1;
                        state_d   = (bit_cnt_d == NB) ? TRAIL : DMARK;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            TRAIL: begin
                if (rise) begin
                    if (in_win(width, 7, 16)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            RTRAIL: begin
                if (rise) begin
                    if (in_win(width, 7, 16)) begin
                        rep_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            HOLD: begin
                if (s2 && tmo) state_d = IDLE;
            end
        endcase
        if (fail) state_d = HOLD;
        err_d = fail;
        // frame_en covers the closing done/err cycle, then drops
        fen_d = (state_d == DMARK) || (state_d == DSPACE) ||
                (state_d == TRAIL) || done_d || (err_d && frame_en);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_out      <= 1'b0;
            bit_strobe   <= 1'b0;
            frame_en     <= 1'b0;
            frame_done   <= 1'b0;
            repeat_pulse <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            bit_out      <= bit_d;
            bit_strobe   <= strobe_d;
            frame_en     <= fen_d;
            frame_done   <= done_d;
            repeat_pulse <= rep_d;
            err          <= err_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_nec_slicer.sv
// Scoreboard bench for ir_nec_slicer: random NEC frames plus directed
// repeat, error, timeout and mid-frame reset scenarios.
module tb_ir_nec_slicer;

    localparam int TD = 4;
    localparam int NB = 32;
    localparam int TO = 220;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ir_in = 1'b1;
    logic bit_out, bit_strobe, frame_en, frame_done;
    logic repeat_pulse, err, busy;

    ir_nec_slicer #(.TICK_DIV(TD), .NBITS(NB), .TO_TICKS(TO)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in),
        .bit_out(bit_out), .bit_strobe(bit_strobe),
        .frame_en(frame_en), .frame_done(frame_done),
        .repeat_pulse(repeat_pulse), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BIT, EV_DONE, EV_REP, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        logic     b;
        longint   lo;
        longint   hi;
    } ev_t;
    typedef enum int {M_OK, M_CUT, M_BAD, M_RST} mode_t;

    ev_t    exp_q[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     n_strobe = 0, n_done = 0, n_rep = 0, n_err = 0;
    logic   prev_end = 1'b0;
    logic   fe_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic b, input longint lo, input longint hi);
        ev_t e;
        e.kind = k;
        e.b    = b;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_kind_t k, input logic b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d expected=none cyc=%0d", k, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        if (k == EV_BIT && e.kind == EV_BIT) chk("bit_value", b, e.b);
        checks++;
        if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL event_time actual=%0d expected=%0d..%0d", cyc, e.lo, e.hi);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (reset) begin
            if (prev_end) chk("frame_en_fall", frame_en, 0);
            prev_end = frame_done | err;
            fe_seen  = fe_seen | frame_en;
            if (frame_done | repeat_pulse | err)
                chk("one_hot", $countones({frame_done, repeat_pulse, err}), 1);
            if (bit_strobe) begin n_strobe++; take(EV_BIT, bit_out); end
            if (frame_done) begin n_done++; take(EV_DONE, 1'b0); end
            if (repeat_pulse) begin n_rep++; take(EV_REP, 1'b0); end
            if (err) begin n_err++; take(EV_ERR, 1'b0); end
        end else begin
            prev_end = 1'b0;
        end
    end

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi - 2, lo + 2));
    endfunction

    task automatic go(input logic v, output longint at);
        @(posedge clk);
        #1;
        ir_in = v;
        at = cyc;
    endtask

    task automatic stay(input int t);
        repeat (t * TD - 1) @(posedge clk);
    endtask

    task automatic edge_ev(input ev_kind_t k, input logic b, input longint at);
        push(k, b, at + 3, at + 3);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_bit_out"}, bit_out, 0);
        chk({tag, "_bit_strobe"}, bit_strobe, 0);
        chk({tag, "_frame_en"}, frame_en, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_repeat"}, repeat_pulse, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Bit i is d[NB-1-i] (MSB first); a data bit is known once the
    // falling edge closing its space arrives.
    task automatic send_frame(input logic [31:0] d, input mode_t mode, input int k);
        longint at;
        go(1'b0, at); stay(rnd(160, 200));
        go(1'b1, at); stay(rnd(80, 100));
        for (int i = 0; i < NB; i++) begin
            go(1'b0, at);
            if (i > 0) begin
                if (mode == M_BAD && i - 1 == k) begin
                    edge_ev(EV_ERR, 1'b0, at);
                    stay(rnd(7, 16));
                    go(1'b1, at);
                    stay(TO + 10);
                    return;
                end
                edge_ev(EV_BIT, d[NB-i], at);
            end
            if (mode == M_CUT && i == k) begin
                push(EV_ERR, 1'b0, at + longint'((TO - 1) * TD), at + longint'((TO + 1) * TD + 6));
                stay(240);
                go(1'b1, at);
                stay(TO + 10);
                return;
            end
            if (mode == M_RST && i == k) begin
                repeat (8) @(posedge clk);
                #1;
                ir_in = 1'b1;
                reset = 1'b0;
                @(posedge clk);
                #1;
                check_idle_outputs("midreset");
                reset = 1'b1;
                stay(20);
                return;
            end
            stay(rnd(7, 16));
            go(1'b1, at);
            if (mode == M_BAD && i == k) stay(22);
            else stay(d[NB-1-i] ? rnd(26, 42) : rnd(7, 16));
        end
        go(1'b0, at);
        edge_ev(EV_BIT, d[0], at);
        stay(rnd(7, 16));
        go(1'b1, at);
        edge_ev(EV_DONE, 1'b0, at);
        stay(rnd(20, 40));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, e0;
        longint at;
        logic [31:0] d;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);

        // reference frame
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        send_frame(32'h00FF_A25D, M_OK, 0);
        chk("ref_strobes", n_strobe - s0, 32);
        chk("ref_done", n_done - d0, 1);
        chk("ref_err", n_err - e0, 0);

        // random frames
        for (int f = 0; f < 3; f++) begin
            d = $urandom;
            d0 = n_done;
            send_frame(d, M_OK, 0);
            chk("rand_done", n_done - d0, 1);
        end

        // repeat code
        s0 = n_strobe;
        fe_seen = 1'b0;
        go(1'b0, at); stay(rnd(160, 200));
        go(1'b1, at); stay(rnd(36, 54));
        go(1'b0, at); stay(rnd(7, 16));
        go(1'b1, at); edge_ev(EV_REP, 1'b0, at);
        stay(30);
        chk("rep_strobes", n_strobe - s0, 0);
        chk("rep_frame_en", fe_seen, 0);
        chk("rep_count", n_rep, 1);

        // short leader mark
        go(1'b0, at); stay(100);
        go(1'b1, at); edge_ev(EV_ERR, 1'b0, at);
        stay(200);
        #1;
        chk("hold_busy", busy, 1);
        chk("hold_frame_en", frame_en, 0);
        stay(30);
        #1;
        chk("hold_exit_busy", busy, 0);

        // line stuck low after bit 10
        s0 = n_strobe; d0 = n_done;
        send_frame($urandom, M_CUT, 10);
        chk("cut_strobes", n_strobe - s0, 10);
        chk("cut_done", n_done - d0, 0);

        // reset during bit 20, then a clean frame
        e0 = n_err;
        send_frame($urandom, M_RST, 20);
        chk("rst_no_err", n_err - e0, 0);
        d0 = n_done;
        send_frame($urandom, M_OK, 0);
        chk("post_rst_done", n_done - d0, 1);

        // space between the 0 and 1 windows
        e0 = n_err;
        send_frame($urandom, M_BAD, int'($urandom_range(25, 0)));
        chk("bad_space_err", n_err - e0, 1);

        repeat (10) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
